fp_to_int: RTL
==============

FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 Parameter FAMILY, default "Stratix 10", target device family ("Stratix 10" or "Agilex").
REQ-002 Parameter EXPONENT_SIZE, default 8, input exponent width; bias = 2^(EXPONENT_SIZE-1)-1.
REQ-003 Parameter MANTISSA_SIZE, default 7, input stored-fraction width; hidden bit is implicit.
REQ-004 Parameter INT_SIZE, default 16, output two's-complement width.
REQ-005 Parameter FIXED_POINT_POSITION, default 0, number of fractional bits in dout.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 valid_in  input  1  input sample qualifier.
REQ-009 sign  input  1  FP sign bit.
REQ-010 exponent  input  EXPONENT_SIZE  biased exponent.
REQ-011 mantissa  input  MANTISSA_SIZE  stored fraction.
REQ-012 valid_out  output  1  dout/flags qualifier.
REQ-013 dout  output  INT_SIZE  signed fixed-point result.
REQ-014 overflow  output  1  result saturated (magnitude out of range or infinity).
REQ-015 invalid  output  1  input was NaN.

Function
REQ-016 Streaming pipeline, no backpressure; a new sample is accepted every cycle that valid_in=1.
REQ-017 Latency LATENCY = 2 + SHIFTER_LATENCY cycles, with SHIFTER_LATENCY = (clog2(INT_SIZE)+1)/2 (4 cycles for defaults), from valid_in to the matching valid_out.
REQ-018 Stage 1 registers the inputs and decodes the class and shift amount k = exponent - bias + FIXED_POINT_POSITION (signed, width sufficient for the full range).
REQ-019 Shift stages split the barrel shift of {1,mantissa} evenly across SHIFTER_LATENCY registered stages: right shift by MANTISSA_SIZE-k when k<=MANTISSA_SIZE, otherwise left shift by k-MANTISSA_SIZE.
REQ-020 The final stage applies the sign by two's-complement negation, saturates, and registers dout, overflow and invalid.
REQ-021 Rounding is truncation toward zero (C cast semantics): discarded fraction bits are dropped from the magnitude before negation.
REQ-022 exponent == 0 (zero or denormal) gives dout=0, overflow=0, invalid=0; denormals are flushed.
REQ-023 k < 0 gives dout=0 with no flags; -0.0 and small negatives give 0, never a negative zero pattern.
REQ-024 Positive input with k >= INT_SIZE-1 gives dout = 2^(INT_SIZE-1)-1 and overflow=1.
REQ-025 Negative input with k > INT_SIZE-1, or k == INT_SIZE-1 with mantissa != 0, gives dout = -2^(INT_SIZE-1) and overflow=1.
REQ-026 Negative input with k == INT_SIZE-1 and mantissa == 0 gives exactly -2^(INT_SIZE-1) and overflow=0.
REQ-027 exponent all ones with mantissa == 0 (infinity) saturates per sign as REQ-024/REQ-025 with overflow=1.
REQ-028 exponent all ones with mantissa != 0 (NaN) gives dout=0, invalid=1, overflow=0, regardless of sign.
REQ-029 Data and flag registers advance every cycle; valid_out is a delayed copy of valid_in; outputs with valid_out=0 are don't-care.
REQ-030 Bubbles (valid_in=0) propagate as valid_out=0 in the same relative cycle positions; there is no reordering or coalescing.

Reset
REQ-031 While rst_n=0 at a rising edge, every valid pipeline bit, dout, overflow and invalid are cleared to 0.
REQ-032 Samples in flight when reset is asserted are discarded; valid_out stays 0 for LATENCY cycles after rst_n returns high unless new valid_in arrives.
REQ-033 Data-path registers other than the outputs need not be reset.

Verification
REQ-034 {sign,exponent,mantissa}=0x3F80 (1.0), FIXED_POINT_POSITION=0 -> after 4 cycles dout=1, flags 0.
REQ-035 0xC060 (-3.5) -> dout=-3 (0xFFFD), flags 0; 0x4700 (32768.0) -> dout=0x7FFF, overflow=1; 0xC700 (-32768.0) -> dout=0x8000, overflow=0.
REQ-036 0x7FC0 (NaN) -> dout=0, invalid=1; 0xFF80 (-inf) -> dout=0x8000, overflow=1; 0x0001 (denormal) -> dout=0.
REQ-037 Exhaustive sweep of all 2^16 input encodings, one per cycle -> every dout/flag matches a shortreal truncate-and-saturate model delayed by LATENCY.
REQ-038 Random valid_in bubble pattern (about 50%) -> valid_out pattern equals valid_in delayed by exactly LATENCY, with data matching.
REQ-039 rst_n pulsed low for 1 cycle mid-stream -> valid_out=0, dout=0, overflow=0 and invalid=0 on the following cycle, with no stale sample emerging afterward.

Source files
------------

// File: rtl/fp_to_int.sv
// Pipelined floating-point to signed fixed-point converter: truncates toward zero,
// saturates out-of-range magnitudes and infinities, and flags NaN inputs.
module fp_to_int #(
  parameter string FAMILY               = "Stratix 10",
  parameter int    EXPONENT_SIZE        = 8,
  parameter int    MANTISSA_SIZE        = 7,
  parameter int    INT_SIZE             = 16,
  parameter int    FIXED_POINT_POSITION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic                     sign,
  input  logic [EXPONENT_SIZE-1:0] exponent,
  input  logic [MANTISSA_SIZE-1:0] mantissa,
  output logic                     valid_out,
  output logic [INT_SIZE-1:0]      dout,
  output logic                     overflow,
  output logic                     invalid
);

  localparam int BIAS            = 2 ** (EXPONENT_SIZE - 1) - 1;
  localparam int SHIFTER_LATENCY = ($clog2(INT_SIZE) + 1) / 2;
  localparam int SL              = SHIFTER_LATENCY;
  localparam int SW              = $clog2(INT_SIZE);
  localparam int BPS             = (SW + SL - 1) / SL;
  localparam int WW              = MANTISSA_SIZE + INT_SIZE;
  localparam int KR              = $clog2(INT_SIZE + FIXED_POINT_POSITION + 1);
  localparam int KW              = ((EXPONENT_SIZE > KR) ? EXPONENT_SIZE : KR) + 2;
  localparam logic signed [KW-1:0] K_TOP = KW'(INT_SIZE - 1);
  localparam logic [INT_SIZE-1:0]  SAT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
  localparam logic [INT_SIZE-1:0]  SAT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};
  // Agilex stage-1 data stays unreset so it can retime into hyper-registers.
  localparam bit RESET_S1_DATA = (FAMILY != "Agilex");

  // Pipeline: index 0 is the decode register, 1..SL are the shift stages.
  logic [WW-1:0]        sh_q   [0:SL];
  logic [SW-1:0]        amt_q  [0:SL-1];
  logic [SL:0]          v_q;
  logic [SL:0]          sgn_q;
  logic [SL:0]          zero_q;
  logic [SL:0]          nan_q;
  logic [SL:0]          ovf_q;

  logic signed [KW-1:0] k_d;
  logic                 exp_max_d;
  logic                 exp_zero_d;
  logic                 nan_d;
  logic                 zero_d;
  logic                 ovf_d;
  logic [SW-1:0]        amt_d;

  always_comb begin
    k_d        = KW'(exponent) + KW'(FIXED_POINT_POSITION) - KW'(BIAS);
    exp_max_d  = &exponent;
    exp_zero_d = ~|exponent;
    nan_d      = exp_max_d && (mantissa != '0);
    zero_d     = 1'b0;
    ovf_d      = 1'b0;
    amt_d      = '0;
    if (exp_max_d) begin
      ovf_d = !nan_d;
    end else if (exp_zero_d || (k_d < 0)) begin
      zero_d = 1'b1;
    end else if (k_d > K_TOP) begin
      ovf_d = 1'b1;
    end else if ((k_d == K_TOP) && (!sign || (mantissa != '0))) begin
      ovf_d = 1'b1;
    end else begin
      // Exactly -2^(INT_SIZE-1) falls through here and is built by the shifter.
      amt_d = SW'(k_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q[0] <= 1'b0;
    end else begin
      v_q[0] <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET_S1_DATA && !rst_n) begin
      sh_q[0]   <= '0;
      amt_q[0]  <= '0;
      sgn_q[0]  <= 1'b0;
      zero_q[0] <= 1'b0;
      nan_q[0]  <= 1'b0;
      ovf_q[0]  <= 1'b0;
    end else begin
      sh_q[0]   <= WW'({1'b1, mantissa});
      amt_q[0]  <= amt_d;
      sgn_q[0]  <= sign;
      zero_q[0] <= zero_d;
      nan_q[0]  <= nan_d;
      ovf_q[0]  <= ovf_d;
    end
  end

  // Each stage applies its own slice of the shift amount; the binary point
  // sits MANTISSA_SIZE bits up, so the low bits end up as discarded fraction.
  for (genvar s = 0; s < SL; s++) begin : g_shift
    localparam logic [SW-1:0] MASK = SW'(((1 << BPS) - 1) << (s * BPS));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[s+1] <= 1'b0;
      end else begin
        v_q[s+1] <= v_q[s];
      end
    end

    always_ff @(posedge clk) begin
      sh_q[s+1]   <= sh_q[s] << (amt_q[s] & MASK);
      sgn_q[s+1]  <= sgn_q[s];
      zero_q[s+1] <= zero_q[s];
      nan_q[s+1]  <= nan_q[s];
      ovf_q[s+1]  <= ovf_q[s];
    end

    if (s < SL - 1) begin : g_amt
      always_ff @(posedge clk) begin
        amt_q[s+1] <= amt_q[s];
      end
    end
  end

  logic [INT_SIZE-1:0] mag_d;
  logic [INT_SIZE-1:0] dout_d;
  logic                overflow_d;
  logic                invalid_d;

  always_comb begin
    mag_d      = INT_SIZE'(sh_q[SL] >> MANTISSA_SIZE);
    dout_d     = '0;
    overflow_d = 1'b0;
    invalid_d  = 1'b0;
    if (nan_q[SL]) begin
      invalid_d = 1'b1;
    end else if (!zero_q[SL]) begin
      if (ovf_q[SL]) begin
        overflow_d = 1'b1;
        dout_d     = sgn_q[SL] ? SAT_MIN : SAT_MAX;
      end else begin
        dout_d = sgn_q[SL] ? -mag_d : mag_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      valid_out <= v_q[SL];
      dout      <= dout_d;
      overflow  <= overflow_d;
      invalid   <= invalid_d;
    end
  end

endmodule
